// File: rtl/range_rand_pkg.sv
// Shared types and LFSR helpers for the constrained-random source.
package range_rand_pkg;

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int unsigned LFSR_MAX_W = 32;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] s,
                                                        input logic [LFSR_MAX_W-1:0] mask);
        return (s >> 1) ^ (s[0] ? mask : '0);
    endfunction

endpackage

// File: rtl/range_rand_gen_if.sv
// Request/response and seed-load signals between a requester and range_rand_gen.
interface range_rand_gen_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LFSR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_lo;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_fallback;
    logic              seed_load;
    logic [LFSR_W-1:0] seed_val;

    modport master (
        output req_valid, req_lo, rsp_ready, seed_load, seed_val,
        input  req_ready, rsp_valid, rsp_data, rsp_fallback
    );

    modport slave (
        input  req_valid, req_lo, rsp_ready, seed_load, seed_val,
        output req_ready, rsp_valid, rsp_data, rsp_fallback
    );
endinterface

// File: rtl/lfsr_galois.sv
// Galois LFSR with step enable and parallel load (load wins over step).
module lfsr_galois
    import range_rand_pkg::*;
#(
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = LFSR_W'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(LFSR_MASK)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/range_rand_gen.sv
// Rejection-sampling random source: returns a value in [lo, 2^WIDTH-1], 0 for small lo,
// or lo itself with rsp_fallback set once MAX_TRIES candidates have been rejected.
module range_rand_gen
    import range_rand_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
    parameter int unsigned       THRESH    = 10,
    parameter int unsigned       MAX_TRIES = 16
) (
    input logic             clk,
    input logic             rst_n,
    range_rand_gen_if.slave bus
);

    localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               fb_q, fb_d;
    logic [TRIES_W-1:0] tries_q, tries_d, tries_inc;
    logic [LFSR_W-1:0]  lfsr_q, seed_eff;
    logic [WIDTH-1:0]   cand;
    logic               seed_take, lfsr_step;

    // Seeding is only honoured while idle so a draw in flight is never disturbed
    assign seed_take = bus.seed_load && (state_q == IDLE);
    assign lfsr_step = ~seed_take;
    assign seed_eff  = (bus.seed_val == '0) ? SEED : bus.seed_val;
    assign cand      = lfsr_q[WIDTH-1:0];
    assign tries_inc = tries_q + TRIES_W'(1);

    lfsr_galois #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (lfsr_step),
        .load     (seed_take),
        .load_val (seed_eff),
        .state    (lfsr_q)
    );

    if (LFSR_W > WIDTH) begin : g_lfsr_hi
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        tries_d = tries_q;
        data_d  = data_q;
        fb_d    = fb_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    lo_d    = bus.req_lo;
                    tries_d = '0;
                    if (bus.req_lo <= WIDTH'(THRESH)) begin
                        state_d = HOLD;
                        data_d  = '0;
                        fb_d    = 1'b0;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            DRAW: begin
                if (cand >= lo_q) begin
                    state_d = HOLD;
                    data_d  = cand;
                    fb_d    = 1'b0;
                end else begin
                    tries_d = tries_inc;
                    if (tries_inc == TRIES_W'(MAX_TRIES)) begin
                        state_d = HOLD;
                        data_d  = lo_q;
                        fb_d    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            tries_q <= '0;
            data_q  <= '0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            tries_q <= tries_d;
            data_q  <= data_d;
            fb_q    <= fb_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.rsp_valid    = (state_q == HOLD);
    assign bus.rsp_data     = data_q;
    assign bus.rsp_fallback = fb_q;

endmodule
